// File: rtl/core_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : core_ctrl_fsm
//  Description : Multi-cycle RV32I sequencer. Walks each instruction through
//                FETCH, DECODE, EXEC, MEM and WB, strobes the datapath, traps
//                illegal encodings and bus timeouts, halts on ecall and
//                counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_ctrl_fsm #(
   parameter int unsigned MEM_TMO = 16,   // cycles a request may wait for ack (>=2)
   parameter int unsigned CNT_W   = 32    // retire counter width
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   output logic             imem_req_o,
   input  logic             imem_ack_i,
   output logic             ir_we_o,
   output logic             dec_en_o,
   input  logic             is_alu_i,
   input  logic             is_load_i,
   input  logic             is_store_i,
   input  logic             is_branch_i,
   input  logic             is_jump_i,
   input  logic             is_ecall_i,
   input  logic             br_taken_i,
   output logic             alu_en_o,
   output logic             dmem_req_o,
   output logic             dmem_we_o,
   input  logic             dmem_ack_i,
   output logic             rf_we_o,
   output logic             pc_we_o,
   output logic [1:0]       pc_sel_o,
   output logic             halted_o,
   output logic             trap_o,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] retire_cnt_o
);

   localparam int unsigned     TMO_W    = $clog2(MEM_TMO);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TMO - 1);

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_e;

   state_e             state_q, state_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               trap_q, trap_d;
   logic               cls_store_q, cls_store_d;
   logic               cls_jump_q, cls_jump_d;
   logic [CNT_W-1:0]   retire_q;
   logic [2:0]         flag_cnt;

   // Exactly one class flag must be set for a legal instruction.
   assign flag_cnt = 3'(is_alu_i) + 3'(is_load_i) + 3'(is_store_i)
                   + 3'(is_branch_i) + 3'(is_jump_i) + 3'(is_ecall_i);

   // Moore outputs: decoded from the state register (and the class latch).
   assign imem_req_o   = (state_q == S_FETCH);
   assign dec_en_o     = (state_q == S_DECODE);
   assign dmem_req_o   = (state_q == S_MEM);
   assign dmem_we_o    = (state_q == S_MEM) && cls_store_q;
   assign rf_we_o      = (state_q == S_WB);
   assign halted_o     = (state_q == S_HALT);
   assign trap_o       = trap_q;
   assign state_o      = state_q;
   assign retire_cnt_o = retire_q;

   // State, timeout counter, trap flag and class latch registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         tmo_q       <= '0;
         trap_q      <= 1'b0;
         cls_store_q <= 1'b0;
         cls_jump_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         trap_q      <= trap_d;
         cls_store_q <= cls_store_d;
         cls_jump_q  <= cls_jump_d;
      end
   end

   // Retire counter: one count per PC update, wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_q <= '0;
      end else if (pc_we_o) begin
         retire_q <= retire_q + CNT_W'(1);
      end
   end

   // Next-state logic and Mealy strobes.
   always_comb begin
      state_d     = state_q;
      tmo_d       = '0;              // any state other than a waiting one clears it
      trap_d      = trap_q;
      cls_store_d = cls_store_q;
      cls_jump_d  = cls_jump_q;
      ir_we_o     = 1'b0;
      alu_en_o    = 1'b0;
      pc_we_o     = 1'b0;
      pc_sel_o    = PC_SEQ;

      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_FETCH;
         end

         S_FETCH: begin
            // An ack on the final allowed cycle still wins over the timeout.
            if (imem_ack_i) begin
               ir_we_o = 1'b1;
               state_d = S_DECODE;
            end else if (tmo_q == TMO_LAST) begin
               trap_d  = 1'b1;
               state_d = S_HALT;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         S_DECODE: begin
            state_d = S_EXEC;
         end

         S_EXEC: begin
            cls_store_d = is_store_i;
            cls_jump_d  = is_jump_i;
            if (flag_cnt != 3'd1) begin
               trap_d  = 1'b1;
               state_d = S_HALT;
            end else if (is_ecall_i) begin
               state_d = S_HALT;
            end else if (is_alu_i || is_jump_i) begin
               alu_en_o = 1'b1;
               state_d  = S_WB;
            end else if (is_load_i || is_store_i) begin
               alu_en_o = 1'b1;
               state_d  = S_MEM;
            end else begin
               // Branch resolves and retires directly from EXEC.
               alu_en_o = 1'b1;
               pc_we_o  = 1'b1;
               pc_sel_o = br_taken_i ? PC_BR : PC_SEQ;
               state_d  = S_FETCH;
            end
         end

         S_MEM: begin
            if (dmem_ack_i) begin
               if (cls_store_q) begin
                  pc_we_o = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (tmo_q == TMO_LAST) begin
               trap_d  = 1'b1;
               state_d = S_HALT;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         S_WB: begin
            pc_we_o  = 1'b1;
            pc_sel_o = cls_jump_q ? PC_JMP : PC_SEQ;
            state_d  = S_FETCH;
         end

         S_HALT: begin
            // PC is left untouched, so a halting ecall re-executes on restart.
            if (start_i) begin
               trap_d  = 1'b0;
               state_d = S_FETCH;
            end
         end

         default: begin
            trap_d  = 1'b1;
            state_d = S_HALT;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_core_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_ctrl_fsm
//  Description : Self-checking bench for core_ctrl_fsm. Each instruction is
//                expanded into its expected per-cycle trace from its class
//                and bus latencies; unrelated inputs are driven with noise.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_ctrl_fsm;

   localparam int MEM_TMO = 16;
   localparam int CNT_W   = 6;
   localparam int CNT_MOD = 1 << CNT_W;

   localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                          ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6;

   // Class flag vector order: {alu, load, store, branch, jump, ecall}
   localparam logic [5:0] F_ALU = 6'b100000, F_LOAD = 6'b010000, F_STORE = 6'b001000,
                          F_BRANCH = 6'b000100, F_JUMP = 6'b000010, F_ECALL = 6'b000001;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start, imem_ack, dmem_ack, br_taken;
   logic             is_alu, is_load, is_store, is_branch, is_jump, is_ecall;
   logic             imem_req, ir_we, dec_en, alu_en, dmem_req, dmem_we;
   logic             rf_we, pc_we, halted, trap;
   logic [1:0]       pc_sel;
   logic [2:0]       state;
   logic [CNT_W-1:0] retire_cnt;

   core_ctrl_fsm #(.MEM_TMO(MEM_TMO), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start),
      .imem_req_o(imem_req), .imem_ack_i(imem_ack), .ir_we_o(ir_we), .dec_en_o(dec_en),
      .is_alu_i(is_alu), .is_load_i(is_load), .is_store_i(is_store),
      .is_branch_i(is_branch), .is_jump_i(is_jump), .is_ecall_i(is_ecall),
      .br_taken_i(br_taken), .alu_en_o(alu_en), .dmem_req_o(dmem_req),
      .dmem_we_o(dmem_we), .dmem_ack_i(dmem_ack), .rf_we_o(rf_we), .pc_we_o(pc_we),
      .pc_sel_o(pc_sel), .halted_o(halted), .trap_o(trap), .state_o(state),
      .retire_cnt_o(retire_cnt)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   // Reference model: architectural counters plus expected strobes this cycle
   int         m_retire = 0;
   logic       m_trap = 1'b0;
   logic [2:0] e_state;
   logic       e_imem, e_irwe, e_dec, e_alu, e_dreq, e_dwe, e_rf, e_pcwe, e_halt;
   logic [1:0] e_pcsel;

   task automatic clr_exp(input logic [2:0] st);
      e_state = st; e_imem = 0; e_irwe = 0; e_dec = 0; e_alu = 0; e_dreq = 0;
      e_dwe = 0; e_rf = 0; e_pcwe = 0; e_halt = 0; e_pcsel = 2'b00;
   endtask

   task automatic noise();
      start     = 1'($urandom); imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
      br_taken  = 1'($urandom); is_alu   = 1'($urandom); is_load  = 1'($urandom);
      is_store  = 1'($urandom); is_branch = 1'($urandom); is_jump = 1'($urandom);
      is_ecall  = 1'($urandom);
   endtask

   task automatic retire();
      m_retire = (m_retire + 1) % CNT_MOD;
   endtask

   task automatic check_now(input string tag);
      logic [14:0] obs, expv;
      obs  = {state, imem_req, ir_we, dec_en, alu_en, dmem_req, dmem_we,
              rf_we, pc_we, pc_sel, halted, trap};
      expv = {e_state, e_imem, e_irwe, e_dec, e_alu, e_dreq, e_dwe,
              e_rf, e_pcwe, e_pcsel, e_halt, m_trap};
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s ctrl {st,ireq,irwe,dec,alu,dreq,dwe,rf,pcwe,sel,hlt,trap}: got %b expected %b",
                tag, obs, expv);
      end
      n_total++;
      assert (retire_cnt === CNT_W'(m_retire)) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s retire_cnt: got %0d expected %0d", tag, retire_cnt, m_retire);
      end
   endtask

   // Inputs are set at posedge+1; outputs checked at posedge+2.
   task automatic step(input string tag);
      #1;
      check_now(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic start_idle(input int waits);
      for (int i = 0; i < waits; i++) begin
         noise(); start = 1'b0; clr_exp(ST_IDLE); step("idle_wait");
      end
      noise(); start = 1'b1; clr_exp(ST_IDLE); step("idle_start");
   endtask

   task automatic resume_halt(input int waits);
      for (int i = 0; i < waits; i++) begin
         noise(); start = 1'b0; clr_exp(ST_HALT); e_halt = 1; step("halt_wait");
      end
      noise(); start = 1'b1; clr_exp(ST_HALT); e_halt = 1; step("halt_start");
      m_trap = 1'b0;
   endtask

   // res: 0 retired (now in FETCH), 1 halted, 2 reset applied (now in IDLE)
   task automatic do_instr(input logic [5:0] fl, input logic br, input int flat,
                           input int mlat, input bit rst_mem, output int res);
      bit ack;
      bit is_st;
      res = 0;
      for (int c = 1; c <= MEM_TMO; c++) begin
         noise(); ack = (c == flat); imem_ack = ack;
         clr_exp(ST_FETCH); e_imem = 1; e_irwe = ack;
         step("fetch");
         if (ack) break;
         if (c == MEM_TMO) begin m_trap = 1'b1; res = 1; return; end
      end
      noise(); clr_exp(ST_DECODE); e_dec = 1; step("decode");

      noise();
      {is_alu, is_load, is_store, is_branch, is_jump, is_ecall} = fl;
      br_taken = br;
      clr_exp(ST_EXEC);
      if ($countones(fl) != 1) begin
         step("exec_illegal"); m_trap = 1'b1; res = 1; return;
      end
      if (fl == F_ECALL) begin step("exec_ecall"); res = 1; return; end
      e_alu = 1;
      if (fl == F_BRANCH) begin
         e_pcwe = 1; e_pcsel = br ? 2'b01 : 2'b00;
         step("exec_branch"); retire(); return;
      end
      step("exec");

      if (fl == F_LOAD || fl == F_STORE) begin
         is_st = (fl == F_STORE);
         for (int c = 1; c <= MEM_TMO; c++) begin
            noise(); ack = (c == mlat); dmem_ack = ack;
            clr_exp(ST_MEM); e_dreq = 1; e_dwe = is_st;
            if (rst_mem && c == 2) begin
               dmem_ack = 1'b0;
               #1; check_now("mem_before_rst");
               rst_n = 1'b0;
               #1; m_retire = 0; m_trap = 1'b0; clr_exp(ST_IDLE);
               check_now("rst_in_mem");
               @(posedge clk); #1;
               check_now("rst_hold");
               start = 1'b0; rst_n = 1'b1;
               @(posedge clk); #1;
               res = 2; return;
            end
            if (ack && is_st) e_pcwe = 1;
            step("mem");
            if (ack) begin
               if (is_st) begin retire(); return; end
               break;
            end
            if (c == MEM_TMO) begin m_trap = 1'b1; res = 1; return; end
         end
      end

      noise(); clr_exp(ST_WB); e_rf = 1; e_pcwe = 1;
      e_pcsel = (fl == F_JUMP) ? 2'b10 : 2'b00;
      step("wb"); retire();
   endtask

   task automatic handle(input int res);
      if (res == 1) resume_halt($urandom_range(0, 2));
      else if (res == 2) start_idle(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int res;
      int r;
      logic [5:0] fl;
      int flat, mlat;

      noise();
      repeat (2) @(posedge clk);
      #1;
      clr_exp(ST_IDLE);
      check_now("in_reset");
      start = 1'b0; rst_n = 1'b1;
      @(posedge clk); #1;
      start_idle(2);

      // Directed: addi with ack in 2nd fetch cycle, load, store, branches
      do_instr(F_ALU, 1'b0, 2, 0, 0, res);             handle(res);
      do_instr(F_LOAD, 1'b0, 1, 3, 0, res);            handle(res);
      do_instr(F_STORE, 1'b0, 3, 2, 0, res);           handle(res);
      do_instr(F_BRANCH, 1'b1, 1, 0, 0, res);          handle(res);
      do_instr(F_BRANCH, 1'b0, 1, 0, 0, res);          handle(res);
      do_instr(F_JUMP, 1'b0, 1, 0, 0, res);            handle(res);
      do_instr(F_ECALL, 1'b0, 1, 0, 0, res);           handle(res);
      do_instr(6'b000000, 1'b0, 1, 0, 0, res);         handle(res);
      do_instr(F_LOAD | F_ALU, 1'b0, 1, 0, 0, res);    handle(res);
      // Timeout boundaries on both buses
      do_instr(F_ALU, 1'b0, MEM_TMO + 1, 0, 0, res);   handle(res);
      do_instr(F_ALU, 1'b0, MEM_TMO, 0, 0, res);       handle(res);
      do_instr(F_LOAD, 1'b0, 1, MEM_TMO + 1, 0, res);  handle(res);
      do_instr(F_STORE, 1'b0, 1, MEM_TMO, 0, res);     handle(res);

      // Randomized instruction stream (also carries retire_cnt through a wrap)
      for (int i = 0; i < 120; i++) begin
         r = $urandom_range(0, 11);
         if (r <= 5)       fl = 6'b000001 << r;
         else if (r == 6)  fl = 6'b000000;
         else if (r == 7)  fl = (6'b000001 << $urandom_range(0, 5)) | (6'b000001 << $urandom_range(0, 5));
         else              fl = F_ALU;
         r = $urandom_range(0, 15);
         flat = (r == 0) ? MEM_TMO + 1 : (r == 1) ? MEM_TMO : $urandom_range(1, 4);
         r = $urandom_range(0, 15);
         mlat = (r == 0) ? MEM_TMO + 1 : (r == 1) ? MEM_TMO : $urandom_range(1, 4);
         do_instr(fl, 1'($urandom), flat, mlat, 0, res);
         handle(res);
      end

      // Asynchronous reset while a load is waiting in MEM
      do_instr(F_LOAD, 1'b0, 1, 5, 1, res);            handle(res);
      do_instr(F_ALU, 1'b0, 1, 0, 0, res);             handle(res);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
